// File: rtl/opcodes.sv
// -----------------------------------------------------------------------------
// opcodes -- shared types and constants for the instruction sequencer.
//   instruction_t      : 32-bit instruction word
//   EBREAK             : encoding that parks the sequencer in HALT
//   WAIT_LIMIT_DEFAULT : default bound on any handshake wait, in cycles
//   seq_state_t        : sequencer state encoding
//   is_misaligned()    : true when an address is not word aligned
// No ports (package).
// -----------------------------------------------------------------------------
package opcodes;

  typedef logic [31:0] instruction_t;

  localparam instruction_t EBREAK             = 32'h0010_0073;
  localparam int           WAIT_LIMIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEM       = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6,
    ERROR     = 3'd7
  } seq_state_t;

  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/core_sequencer_if.sv
// -----------------------------------------------------------------------------
// core_sequencer_if -- handshake bundle between the sequencer and the
// instruction memory, decoder, ALU, data memory and register bank.
//   master : sequencer side (drives requests/strobes, receives acks/results)
//   slave  : environment side (the mirror image)
// Signals:
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction fetch
//   instr/dec_enable                       : decoder capture
//   alu_start/alu_done/mem_op/rd_write/
//   branch_taken/branch_target             : execute handshake and results
//   mem_req/mem_ack                        : data memory handshake
//   rf_we                                  : register bank write strobe
// -----------------------------------------------------------------------------
interface core_sequencer_if;
  import opcodes::*;

  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_ack;
  logic [31:0]  imem_rdata;
  instruction_t instr;
  logic         dec_enable;
  logic         alu_start;
  logic         alu_done;
  logic         mem_op;
  logic         rd_write;
  logic         branch_taken;
  logic [31:0]  branch_target;
  logic         mem_req;
  logic         mem_ack;
  logic         rf_we;

  modport master (
    output imem_req, imem_addr, instr, dec_enable, alu_start, mem_req, rf_we,
    input  imem_ack, imem_rdata, alu_done, mem_op, rd_write, branch_taken,
           branch_target, mem_ack
  );

  modport slave (
    input  imem_req, imem_addr, instr, dec_enable, alu_start, mem_req, rf_we,
    output imem_ack, imem_rdata, alu_done, mem_op, rd_write, branch_taken,
           branch_target, mem_ack
  );

endinterface

// File: rtl/seq_wait_timer.sv
// -----------------------------------------------------------------------------
// seq_wait_timer -- counts cycles spent waiting on a handshake.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : load zero on the next edge (entry into a waiting state)
//   count_en  : awaited ack/done is low this cycle
//   last      : counter holds WAIT_LIMIT-1, so one more idle cycle reaches
//               the limit; an ack in this cycle is still accepted
// -----------------------------------------------------------------------------
module seq_wait_timer
  import opcodes::*;
#(
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic last
);

  localparam logic [15:0] LIMIT_M1 = 16'(WAIT_LIMIT - 1);

  logic [15:0] count_r;

  // Wait-cycle counter: clear has priority over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else if (count_en) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // Decoded from the count alone so the FSM can use it without a loop.
  assign last = (count_r == LIMIT_M1);

endmodule

// File: rtl/core_sequencer.sv
// -----------------------------------------------------------------------------
// core_sequencer -- multi-cycle instruction sequencer:
//   IDLE -> FETCH -> DECODE -> EXECUTE -> [MEM] -> WRITEBACK -> FETCH ...
// with HALT on EBREAK and ERROR on handshake timeout or misaligned branch.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   start        : level, leaves IDLE when high
//   bus          : core_sequencer_if.master handshake bundle
//   pc           : program counter (also drives bus.imem_addr)
//   instr_count  : retired instruction count, wraps at 2^32
//   halted/error : terminal state flags, cleared only by reset
// All strobes are registers loaded from the next state, so each is high
// exactly for the cycles the FSM spends in the matching state.
// -----------------------------------------------------------------------------
module core_sequencer
  import opcodes::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          WAIT_LIMIT = WAIT_LIMIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  core_sequencer_if.master bus,
  output logic [31:0] pc,
  output logic [31:0] instr_count,
  output logic        halted,
  output logic        error
);

  seq_state_t   state_r;
  seq_state_t   state_s;

  logic [31:0]  pc_r;
  logic [31:0]  instr_count_r;
  instruction_t instr_r;
  logic         rd_write_r;
  logic         branch_taken_r;
  logic [31:0]  branch_target_r;

  logic         imem_req_r;
  logic         dec_enable_r;
  logic         alu_start_r;
  logic         mem_req_r;
  logic         rf_we_r;
  logic         halted_r;
  logic         error_r;

  logic         rd_write_s;
  logic         wait_s;
  logic         timer_clear_s;
  logic         timer_last_s;

  // Cycles in a waiting state whose ack/done is still low.
  assign wait_s = ((state_r == FETCH)   && !bus.imem_ack) ||
                  ((state_r == EXECUTE) && !bus.alu_done) ||
                  ((state_r == MEM)     && !bus.mem_ack);

  // The counter restarts only on entry, never while staying put.
  assign timer_clear_s = (state_s != state_r) &&
                         ((state_s == FETCH) || (state_s == EXECUTE) ||
                          (state_s == MEM));

  seq_wait_timer #(
    .WAIT_LIMIT (WAIT_LIMIT)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear_s),
    .count_en (wait_s),
    .last     (timer_last_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic; an ack arriving together with timer_last wins.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = FETCH;
        else       state_s = IDLE;
      end
      FETCH: begin
        if (bus.imem_ack)      state_s = DECODE;
        else if (timer_last_s) state_s = ERROR;
        else                   state_s = FETCH;
      end
      DECODE: begin
        if (instr_r == EBREAK) state_s = HALT;
        else                   state_s = EXECUTE;
      end
      EXECUTE: begin
        if (bus.alu_done) begin
          if (bus.branch_taken && is_misaligned(bus.branch_target)) state_s = ERROR;
          else if (bus.mem_op)                                      state_s = MEM;
          else                                                      state_s = WRITEBACK;
        end else if (timer_last_s) begin
          state_s = ERROR;
        end else begin
          state_s = EXECUTE;
        end
      end
      MEM: begin
        if (bus.mem_ack)       state_s = WRITEBACK;
        else if (timer_last_s) state_s = ERROR;
        else                   state_s = MEM;
      end
      WRITEBACK: state_s = FETCH;
      HALT:      state_s = HALT;
      ERROR:     state_s = ERROR;
      default:   state_s = ERROR;
    endcase
  end

  // rd_write as it will be after this edge; lets rf_we be registered while
  // still covering the EXECUTE->WRITEBACK direct path.
  always_comb begin
    rd_write_s = rd_write_r;
    if ((state_r == EXECUTE) && bus.alu_done) rd_write_s = bus.rd_write;
    else                                      rd_write_s = rd_write_r;
  end

  // Datapath: instruction latch, execute results, pc and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_r            <= RESET_PC;
      instr_count_r   <= 32'd0;
      instr_r         <= 32'd0;
      rd_write_r      <= 1'b0;
      branch_taken_r  <= 1'b0;
      branch_target_r <= 32'd0;
    end else begin
      if ((state_r == FETCH) && bus.imem_ack) begin
        instr_r <= bus.imem_rdata;
      end
      if ((state_r == EXECUTE) && bus.alu_done) begin
        rd_write_r      <= bus.rd_write;
        branch_taken_r  <= bus.branch_taken;
        branch_target_r <= bus.branch_target;
      end
      if (state_r == WRITEBACK) begin
        pc_r          <= branch_taken_r ? branch_target_r : (pc_r + 32'd4);
        instr_count_r <= instr_count_r + 32'd1;
      end
    end
  end

  // Registered strobes and flags, loaded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      imem_req_r   <= 1'b0;
      dec_enable_r <= 1'b0;
      alu_start_r  <= 1'b0;
      mem_req_r    <= 1'b0;
      rf_we_r      <= 1'b0;
      halted_r     <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      imem_req_r   <= (state_s == FETCH);
      dec_enable_r <= (state_s == DECODE);
      alu_start_r  <= (state_s == EXECUTE) && (state_r != EXECUTE);
      mem_req_r    <= (state_s == MEM);
      rf_we_r      <= (state_s == WRITEBACK) && rd_write_s;
      halted_r     <= (state_s == HALT);
      error_r      <= (state_s == ERROR);
    end
  end

  assign bus.imem_req   = imem_req_r;
  assign bus.imem_addr  = pc_r;
  assign bus.instr      = instr_r;
  assign bus.dec_enable = dec_enable_r;
  assign bus.alu_start  = alu_start_r;
  assign bus.mem_req    = mem_req_r;
  assign bus.rf_we      = rf_we_r;
  assign pc             = pc_r;
  assign instr_count    = instr_count_r;
  assign halted         = halted_r;
  assign error          = error_r;

endmodule

// File: tb/tb_core_sequencer.sv
// -----------------------------------------------------------------------------
// tb_core_sequencer -- directed, self-checking bench for core_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_core_sequencer;

  localparam logic [31:0] ADDI = 32'h0010_0093;
  localparam logic [31:0] BEQ  = 32'h0000_0063;
  localparam logic [31:0] LW   = 32'h0000_2083;
  localparam logic [31:0] EBRK = 32'h0010_0073;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic [31:0] instr_count;
  logic        halted;
  logic        error;

  int errors = 0;
  int checks = 0;

  core_sequencer_if bus();

  core_sequencer #(
    .RESET_PC   (32'h0000_0000),
    .WAIT_LIMIT (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bus         (bus),
    .pc          (pc),
    .instr_count (instr_count),
    .halted      (halted),
    .error       (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = 32'd0;
    bus.alu_done      = 1'b0;
    bus.mem_op        = 1'b0;
    bus.rd_write      = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'd0;
    bus.mem_ack       = 1'b0;
  endtask

  // Leaves the DUT in IDLE at a falling edge.
  task automatic do_reset();
    rst   = 1'b1;
    start = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // From IDLE: ends on the first FETCH cycle.
  task automatic go_fetch();
    start = 1'b1;
    @(negedge clk);
  endtask

  // From a FETCH cycle: acks immediately, ends on the DECODE cycle.
  task automatic feed_now(input logic [31:0] word);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
  endtask

  // From DECODE: alu_done on the first EXECUTE cycle, ends one cycle later.
  task automatic exec_now(input logic mem, input logic rdw, input logic bt,
                          input logic [31:0] tgt);
    @(negedge clk);
    bus.alu_done      = 1'b1;
    bus.mem_op        = mem;
    bus.rd_write      = rdw;
    bus.branch_taken  = bt;
    bus.branch_target = tgt;
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++; if (pc !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h expected %h", pc, 32'd0); end
    checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %h expected 0", instr_count); end
    checks++; if (bus.instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h expected 0", bus.instr); end
    checks++; if ({bus.imem_req, bus.dec_enable, bus.alu_start, bus.mem_req, bus.rf_we, halted, error} !== 7'd0) begin
      errors++; $display("FAIL reset_strobes: got %b expected 0000000",
        {bus.imem_req, bus.dec_enable, bus.alu_start, bus.mem_req, bus.rf_we, halted, error});
    end
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL idle_hold: imem_req got %b expected 0", bus.imem_req); end
  endtask

  task automatic test_addi();
    do_reset();
    go_fetch();
    checks++; if (bus.imem_req !== 1'b1) begin errors++; $display("FAIL addi_req: got %b expected 1", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'd0) begin errors++; $display("FAIL addi_addr: got %h expected 0", bus.imem_addr); end
    @(negedge clk);
    checks++; if (bus.dec_enable !== 1'b0) begin errors++; $display("FAIL addi_wait_dec: got %b expected 0", bus.dec_enable); end
    feed_now(ADDI);
    checks++; if (bus.instr !== ADDI) begin errors++; $display("FAIL addi_instr: got %h expected %h", bus.instr, ADDI); end
    checks++; if (bus.dec_enable !== 1'b1) begin errors++; $display("FAIL addi_dec: got %b expected 1", bus.dec_enable); end
    @(negedge clk);
    checks++; if (bus.alu_start !== 1'b1) begin errors++; $display("FAIL addi_alu_start: got %b expected 1", bus.alu_start); end
    bus.alu_done = 1'b1;
    bus.rd_write = 1'b1;
    @(negedge clk);
    clear_inputs();
    checks++; if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL addi_rf_we: got %b expected 1", bus.rf_we); end
    checks++; if (bus.alu_start !== 1'b0) begin errors++; $display("FAIL addi_alu_once: got %b expected 0", bus.alu_start); end
    @(negedge clk);
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL addi_rf_we_once: got %b expected 0", bus.rf_we); end
    checks++; if (pc !== 32'd4) begin errors++; $display("FAIL addi_pc: got %h expected 4", pc); end
    checks++; if (instr_count !== 32'd1) begin errors++; $display("FAIL addi_count: got %h expected 1", instr_count); end
    checks++; if (bus.imem_addr !== 32'd4 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL addi_next_fetch: addr %h req %b expected 4 1", bus.imem_addr, bus.imem_req);
    end
  endtask

  // Continues from test_addi: pc=4, FETCH.
  task automatic test_branch();
    feed_now(BEQ);
    exec_now(1'b0, 1'b0, 1'b1, 32'h0000_0100);
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL br_no_rf_we: got %b expected 0", bus.rf_we); end
    @(negedge clk);
    checks++; if (bus.imem_addr !== 32'h0000_0100) begin errors++; $display("FAIL br_target: got %h expected 00000100", bus.imem_addr); end
    checks++; if (instr_count !== 32'd2) begin errors++; $display("FAIL br_count: got %h expected 2", instr_count); end
    feed_now(BEQ);
    exec_now(1'b0, 1'b1, 1'b1, 32'h0000_0102);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL br_misaligned_err: got %b expected 1", error); end
    checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL br_misaligned_rf_we: got %b expected 0", bus.rf_we); end
    repeat (3) @(negedge clk);
    checks++; if (pc !== 32'h0000_0100) begin errors++; $display("FAIL br_misaligned_pc: got %h expected 00000100", pc); end
    checks++; if ({error, bus.imem_req, bus.alu_start, bus.mem_req} !== 4'b1000) begin
      errors++; $display("FAIL br_error_hold: got %b expected 1000", {error, bus.imem_req, bus.alu_start, bus.mem_req});
    end
  endtask

  task automatic test_load();
    int req_cycles;
    int we_cycles;
    int we_at;
    req_cycles = 0;
    we_cycles  = 0;
    we_at      = -1;
    do_reset();
    go_fetch();
    feed_now(LW);
    exec_now(1'b1, 1'b1, 1'b0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      if (bus.mem_req === 1'b1) req_cycles++;
      if (bus.rf_we === 1'b1) begin we_cycles++; we_at = i; end
      bus.mem_ack = (i == 3);
      @(negedge clk);
    end
    bus.mem_ack = 1'b0;
    checks++; if (req_cycles !== 4) begin errors++; $display("FAIL load_mem_req_len: got %0d expected 4", req_cycles); end
    checks++; if (we_cycles !== 1) begin errors++; $display("FAIL load_rf_we_count: got %0d expected 1", we_cycles); end
    checks++; if (we_at !== 4) begin errors++; $display("FAIL load_rf_we_cycle: got %0d expected 4", we_at); end
    checks++; if (pc !== 32'd4) begin errors++; $display("FAIL load_pc: got %h expected 4", pc); end
  endtask

  task automatic test_ebreak();
    int dec_pulses;
    int alu_pulses;
    int pc_moves;
    dec_pulses = 0;
    alu_pulses = 0;
    pc_moves   = 0;
    do_reset();
    go_fetch();
    feed_now(EBRK);
    for (int i = 0; i < 20; i++) begin
      if (bus.dec_enable === 1'b1) dec_pulses++;
      if (bus.alu_start === 1'b1) alu_pulses++;
      if (pc !== 32'd0) pc_moves++;
      bus.alu_done = 1'b1;
      bus.imem_ack = 1'b1;
      @(negedge clk);
    end
    clear_inputs();
    checks++; if (dec_pulses !== 1) begin errors++; $display("FAIL ebreak_dec: got %0d expected 1", dec_pulses); end
    checks++; if (alu_pulses !== 0) begin errors++; $display("FAIL ebreak_alu: got %0d expected 0", alu_pulses); end
    checks++; if (pc_moves !== 0) begin errors++; $display("FAIL ebreak_pc_frozen: moved %0d cycles expected 0", pc_moves); end
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ebreak_halted: got %b expected 1", halted); end
    checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL ebreak_count: got %h expected 0", instr_count); end
  endtask

  task automatic test_timeout();
    do_reset();
    go_fetch();
    repeat (15) @(negedge clk);
    checks++; if (error !== 1'b0 || bus.imem_req !== 1'b1) begin
      errors++; $display("FAIL to_fetch16: error %b req %b expected 0 1", error, bus.imem_req);
    end
    @(negedge clk);
    checks++; if (error !== 1'b1) begin errors++; $display("FAIL to_error: got %b expected 1", error); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL to_req_drop: got %b expected 0", bus.imem_req); end
    do_reset();
    go_fetch();
    repeat (15) @(negedge clk);
    feed_now(ADDI);
    checks++; if (error !== 1'b0) begin errors++; $display("FAIL to_late_ack_err: got %b expected 0", error); end
    checks++; if (bus.dec_enable !== 1'b1) begin errors++; $display("FAIL to_late_ack_dec: got %b expected 1", bus.dec_enable); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    go_fetch();
    feed_now(ADDI);
    exec_now(1'b0, 1'b1, 1'b0, 32'd0);
    @(negedge clk);
    feed_now(LW);
    exec_now(1'b1, 1'b1, 1'b0, 32'd0);
    checks++; if (bus.mem_req !== 1'b1 || pc !== 32'd4) begin
      errors++; $display("FAIL rst_mem_setup: mem_req %b pc %h expected 1 00000004", bus.mem_req, pc);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req_async: got %b expected 0", bus.mem_req); end
    checks++; if (pc !== 32'd0 || instr_count !== 32'd0 || bus.instr !== 32'd0) begin
      errors++; $display("FAIL rst_mem_values: pc %h count %h instr %h expected 0 0 0", pc, instr_count, bus.instr);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'd0) begin
      errors++; $display("FAIL rst_restart: req %b addr %h expected 1 00000000", bus.imem_req, bus.imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_branch();
    test_load();
    test_ebreak();
    test_timeout();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter RESET_PC, 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter WAIT_LIMIT, 16, max cycles any handshake wait may last before error.
REQ-003 clk  in  1  single rising-edge clock.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  level; leaves IDLE when high.
REQ-006 imem_req  out  1  instruction fetch request.
REQ-007 imem_addr  out  32  fetch address, equals pc.
REQ-008 imem_ack  in  1  fetch complete; imem_rdata valid this cycle.
REQ-009 imem_rdata  in  32  fetched instruction.
REQ-010 instr  out  instruction_t  latched instruction driven to the decoder.
REQ-011 dec_enable  out  1  one-cycle decoder capture strobe.
REQ-012 alu_start  out  1  one-cycle execute-start pulse.
REQ-013 alu_done  in  1  execute complete.
REQ-014 mem_op  in  1  current instruction needs data memory, sampled on alu_done.
REQ-015 mem_req  out  1  data memory request; mem_ack  in  1  completion.
REQ-016 rd_write  in  1  current instruction writes rd, sampled on alu_done.
REQ-017 branch_taken  in  1  and branch_target  in  32, sampled on alu_done.
REQ-018 rf_we  out  1  one-cycle register-bank write strobe.
REQ-019 pc  out  32; instr_count  out  32; halted  out  1; error  out  1.

Function
REQ-020 States: IDLE, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT, ERROR; one state register.
REQ-021 IDLE -> FETCH when start=1; otherwise hold.
REQ-022 FETCH: imem_req=1 every cycle; on imem_ack latch imem_rdata into instr, -> DECODE next cycle.
REQ-023 DECODE: dec_enable=1 for exactly one cycle; if instr==EBREAK -> HALT, else -> EXECUTE.
REQ-024 EXECUTE: alu_start=1 on the first cycle in state only; on alu_done latch mem_op, rd_write, branch_taken, branch_target; -> MEM if mem_op=1, else -> WRITEBACK.
REQ-025 alu_done in the same cycle as alu_start is legal and completes EXECUTE in one cycle.
REQ-026 MEM: mem_req=1 until mem_ack; on mem_ack -> WRITEBACK.
REQ-027 WRITEBACK (one cycle): rf_we=latched rd_write; pc <= latched branch_taken ? latched branch_target : pc+4, modulo 2^32; instr_count <= instr_count+1, wrapping at 2^32; -> FETCH.
REQ-028 Wait counter clears on entry to FETCH, EXECUTE and MEM and counts each cycle the awaited ack/done is low; reaching WAIT_LIMIT -> ERROR.
REQ-029 An ack or done arriving in the same cycle the counter reaches WAIT_LIMIT is accepted; no error.
REQ-030 HALT: halted=1, all strobes 0, pc and instr_count frozen; exits only by reset.
REQ-031 ERROR: error=1, all strobes 0; exits only by reset.
REQ-032 A branch_target with bits[1:0]!=0 on a taken branch -> ERROR instead of WRITEBACK; pc is not updated.
REQ-033 Acks and done received outside their waiting state are ignored.
REQ-034 Strobes and requests are registered outputs; they are decoded from state only, never combinationally from inputs.

Reset
REQ-035 Asserting rst at any time forces IDLE immediately, abandoning any in-flight handshake.
REQ-036 Reset values: pc=RESET_PC, instr=0, instr_count=0, all strobes and requests 0, halted=0, error=0, wait counter 0.

Structure
REQ-037 The state enum seq_state_t and WAIT_LIMIT default belong in package opcodes; EBREAK and instruction_t are taken from opcodes.
REQ-038 One sub-module, seq_wait_timer (counter plus limit compare), is natural; everything else stays in one module.

Verification
REQ-039 ADDI fetched with imem_ack on 2nd cycle, alu_done immediate, rd_write=1 -> rf_we pulse once, pc 0->4, instr_count=1.
REQ-040 Taken branch, branch_target=0x100 -> next imem_addr=0x100; branch_target=0x102 -> error=1, pc unchanged.
REQ-041 Load with mem_op=1, mem_ack after 3 cycles -> mem_req high exactly 4 cycles, then rf_we pulse.
REQ-042 EBREAK fetched -> dec_enable one pulse, halted=1, no alu_start, pc frozen for 20 cycles.
REQ-043 imem_ack withheld with WAIT_LIMIT=16 -> error=1 after 16 FETCH cycles; ack on the 16th cycle -> no error.
REQ-044 rst asserted mid-MEM -> mem_req drops without a clock edge; outputs match reset values; start restarts fetch at RESET_PC.
